spi_host_arb: RTL and testbench

//  Single-clock SPI host that sequences 44-bit frames {op[1:0], addr[9:0], data[31:0]} into spi_sub.

---
 rtl/spi_host_arb.sv | 191 +++++++++++++++++++
 tb/tb_spi_host_arb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_arb.sv
// Round-robin arbitrated SPI host: serialises 44-bit {op, addr, data} frames to a
// single spi_sub and returns the captured echo to the granted requester.
module spi_host_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned TURN = 2,
  parameter int unsigned GAP  = 2
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [10*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int unsigned FW     = 44;
  localparam int unsigned MAXREQ = 4;
  localparam int          NREQ_I = int'(NREQ);

  typedef struct packed {
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [31:0] data;
  } frame_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_OUT,
    TURN_WAIT,
    SHIFT_IN,
    DONE,
    GAP_WAIT
  } state_t;

  state_t       state;
  frame_t       tx_q;
  logic [FW-1:0] tx_bits;
  logic [FW-1:0] rx_q;
  logic [5:0]   bit_cnt;
  logic [2:0]   wait_cnt;
  logic [1:0]   rr_q;
  logic [1:0]   id_q;

  frame_t       req_frame [MAXREQ];
  logic [3:0]   valid_pad;
  logic [2:0]   cand;
  logic [2:0]   rr_inc;
  logic         grant_any;
  logic [1:0]   grant_id;
  logic [1:0]   rr_next;

  assign tx_bits = tx_q;

  // Unpack the flat per-requester buses into a fixed 4-entry table
  always_comb begin
    for (int i = 0; i < int'(MAXREQ); i++) begin
      req_frame[i] = '0;
    end
    for (int i = 0; i < NREQ_I; i++) begin
      req_frame[i] = {req_op[2*i +: 2], req_addr[10*i +: 10], req_wdata[32*i +: 32]};
    end
  end

  // Round-robin pick: lowest index at or above rr_q, wrapping at NREQ
  always_comb begin
    valid_pad = 4'(req_valid);
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = NREQ_I - 1; i >= 0; i--) begin
      cand = 3'(rr_q) + 3'(i);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (valid_pad[cand[1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[1:0];
      end
    end
    rr_inc  = 3'(grant_id) + 3'd1;
    if (rr_inc >= 3'(NREQ)) rr_inc = '0;
    rr_next = rr_inc[1:0];
  end

  // Frame sequencer with registered SPI pins and response outputs
  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rr_q      <= '0;
      id_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cs_n <= 1'b1;
          mosi <= 1'b0;
          if (grant_any) begin
            req_ready <= NREQ'(4'b0001 << grant_id);
            tx_q      <= req_frame[grant_id];
            id_q      <= grant_id;
            rr_q      <= rr_next;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            // Reserved ops skip the bus and answer with an error next cycle
            state     <= req_frame[grant_id].op[1] ? DONE : SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          cs_n <= 1'b0;
          mosi <= tx_bits[6'(FW - 1) - bit_cnt];
          if (bit_cnt == 6'(FW - 1)) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            state    <= TURN_WAIT;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        TURN_WAIT: begin
          mosi <= 1'b0;
          if (wait_cnt == 3'(TURN - 1)) begin
            wait_cnt <= '0;
            state    <= SHIFT_IN;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        SHIFT_IN: begin
          rx_q <= {rx_q[FW-2:0], miso};
          if (bit_cnt == 6'(FW - 1)) begin
            bit_cnt <= '0;
            state   <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        DONE: begin
          cs_n      <= 1'b1;
          mosi      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          if (tx_q.op[1]) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            rsp_rdata <= rx_q[31:0];
            // Writes must echo the whole frame; reads only the op/addr header
            rsp_err   <= tx_q.op[0] ? (rx_q != tx_bits)
                                    : (rx_q[FW-1:32] != tx_bits[FW-1:32]);
          end
          wait_cnt <= '0;
          state    <= GAP_WAIT;
        end
        GAP_WAIT: begin
          cs_n <= 1'b1;
          mosi <= 1'b0;
          if (wait_cnt == 3'(GAP - 1)) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          cs_n  <= 1'b1;
          mosi  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_arb.sv
// Bench for spi_host_arb: loopback spi_sub model, two requesters, and a response
// scoreboard filled at grant time and drained when rsp_valid pulses.
module tb_spi_host_arb;

  localparam int NREQ = 2;
  localparam int TURN = 2;
  localparam int GAP  = 2;

  logic              sclk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [10*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  logic        r_valid [NREQ];
  logic [1:0]  r_op    [NREQ];
  logic [9:0]  r_addr  [NREQ];
  logic [31:0] r_wdata [NREQ];

  assign req_valid = {r_valid[1], r_valid[0]};
  assign req_op    = {r_op[1], r_op[0]};
  assign req_addr  = {r_addr[1], r_addr[0]};
  assign req_wdata = {r_wdata[1], r_wdata[0]};

  spi_host_arb #(.NREQ(NREQ), .TURN(TURN), .GAP(GAP)) dut (
    .sclk(sclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb [$];
  int   grant_ids [$];
  int   grant_cycs [$];
  int   rsp_log [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = -1;
  int cs_fall_cyc = -1;
  int cs_rise_cyc = -1;
  int cs_falls = 0;
  logic prev_cs;

  bit [31:0] ref_mem [1024];
  bit [31:0] sub_mem [1024];
  logic [43:0] sub_sr;
  logic [43:0] sub_resp;
  logic [43:0] sub_frame;
  logic [6:0]  sub_cnt;
  logic        miso_zero;
  logic        corrupt_addr;

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    forever begin
      @(posedge sclk);
      cyc++;
    end
  end

  // Loopback spi_sub: writes store data and echo the frame, reads return memory
  assign sub_frame = {sub_sr[42:0], mosi};
  always @(posedge sclk) begin
    if (cs_n !== 1'b0) begin
      sub_cnt <= '0;
      miso    <= 1'b0;
    end else begin
      sub_cnt <= sub_cnt + 7'd1;
      if (sub_cnt < 7'd44) sub_sr <= sub_frame;
      if (sub_cnt == 7'd43) begin
        if (sub_frame[43:42] == 2'b01) sub_mem[sub_frame[41:32]] <= sub_frame[31:0];
        sub_resp <= {sub_frame[43:42], sub_frame[41:32] ^ {9'd0, corrupt_addr},
                     (sub_frame[43:42] == 2'b01) ? sub_frame[31:0] : sub_mem[sub_frame[41:32]]};
      end
      if (sub_cnt >= 7'd44 && sub_cnt <= 7'd87)
        miso <= miso_zero ? 1'b0 : sub_resp[6'(7'd87 - sub_cnt)];
    end
  end

  // Response scoreboard and idle-pin monitor
  initial begin
    exp_t e;
    prev_cs = 1'b1;
    forever begin
      @(negedge sclk);
      if (cs_n === 1'b0 && prev_cs === 1'b1) begin
        cs_fall_cyc = cyc;
        cs_falls++;
      end
      if (cs_n === 1'b1 && prev_cs === 1'b0) cs_rise_cyc = cyc;
      prev_cs = cs_n;
      if (cs_n === 1'b1) begin
        checks++;
        if (mosi !== 1'b0) begin
          errors++;
          $display("FAIL mosi_idle cyc=%0d mosi=%b required 0", cyc, mosi);
        end
      end
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        rsp_log.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d id=%0d rdata=%h err=%b required no response",
                   cyc, rsp_id, rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_rdata, rsp_err} !== e) begin
            errors++;
            $display("FAIL rsp cyc=%0d got id=%0d rdata=%h err=%b required id=%0d rdata=%h err=%b",
                     cyc, rsp_id, rsp_rdata, rsp_err, e.id, e.rdata, e.err);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Present a request, wait for its grant and push the expected response
  task automatic issue(input int id, input logic [1:0] op, input logic [9:0] addr,
                       input logic [31:0] data, output int gcyc);
    exp_t e;
    bit   got;
    got = 1'b0;
    gcyc = -1;
    r_op[id] = op;
    r_addr[id] = addr;
    r_wdata[id] = data;
    r_valid[id] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge sclk);
      if (req_ready[id] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout req=%0d got no ready required ready within 400 cycles", id);
      r_valid[id] = 1'b0;
      return;
    end
    gcyc = cyc;
    if (req_ready !== NREQ'(1 << id)) begin
      errors++;
      $display("FAIL ready_onehot req=%0d got %b required %b", id, req_ready, NREQ'(1 << id));
    end
    grant_ids.push_back(id);
    grant_cycs.push_back(cyc);
    e.id = 2'(id);
    if (op[1]) begin
      e.rdata = '0;
      e.err = 1'b1;
    end else if (op == 2'b01) begin
      ref_mem[addr] = data;
      e.rdata = miso_zero ? 32'd0 : data;
      e.err = miso_zero;
    end else begin
      e.rdata = miso_zero ? 32'd0 : ref_mem[addr];
      e.err = miso_zero | corrupt_addr;
    end
    sb.push_back(e);
    r_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge sclk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rsp_timeout pending=%0d required 0 within 300 cycles", sb.size());
      sb.delete();
    end
    @(negedge sclk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    checks++;
    if ({cs_n, mosi, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err} !==
        {1'b1, 1'b0, 2'b00, 1'b0, 2'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got cs_n=%b mosi=%b ready=%b rv=%b id=%0d rdata=%h err=%b required 1 0 00 0 0 0 0",
               cs_n, mosi, req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    repeat (3) @(negedge sclk);
    checks++;
    if (req_ready !== 2'b00 || cs_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_req got ready=%b cs_n=%b required 00 1", req_ready, cs_n);
    end
  endtask

  task automatic test_write();
    int t;
    issue(0, 2'b01, 10'h3FF, 32'h22222222, t);
    wait_drain();
    if (t >= 0) begin
      checks++;
      if (cs_fall_cyc != t + 1 || cs_rise_cyc != t + 91) begin
        errors++;
        $display("FAIL cs_window got fall=%0d rise=%0d required %0d %0d",
                 cs_fall_cyc, cs_rise_cyc, t + 1, t + 91);
      end
      checks++;
      if (last_rsp_cyc != t + 91) begin
        errors++;
        $display("FAIL write_latency got %0d required %0d", last_rsp_cyc, t + 91);
      end
    end
  endtask

  task automatic test_read();
    int t;
    issue(0, 2'b00, 10'h3FF, 32'h0, t);
    wait_drain();
    issue(0, 2'b01, 10'h000, 32'h11111111, t);
    wait_drain();
    issue(0, 2'b00, 10'h000, 32'hDEADBEEF, t);
    wait_drain();
  endtask

  task automatic test_reserved();
    int t;
    int falls0;
    falls0 = cs_falls;
    issue(1, 2'b10, 10'h055, 32'h12345678, t);
    wait_drain();
    if (t >= 0) begin
      checks++;
      if (last_rsp_cyc != t + 1) begin
        errors++;
        $display("FAIL reserved_latency got %0d required %0d", last_rsp_cyc, t + 1);
      end
    end
    checks++;
    if (cs_falls != falls0) begin
      errors++;
      $display("FAIL reserved_cs got %0d cs_n falls required 0", cs_falls - falls0);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2, t3;
    grant_ids.delete();
    grant_cycs.delete();
    rsp_log.delete();
    fork
      begin
        issue(0, 2'b00, 10'h3FF, 32'h0, t0);
        issue(0, 2'b01, 10'h010, 32'hA5A5A5A5, t2);
      end
      begin
        issue(1, 2'b01, 10'h020, 32'h0BADF00D, t1);
        issue(1, 2'b00, 10'h010, 32'h0, t3);
      end
    join
    wait_drain();
    checks++;
    if (grant_ids.size() != 4 || rsp_log.size() != 4) begin
      errors++;
      $display("FAIL rr_count got grants=%0d rsps=%0d required 4 4", grant_ids.size(), rsp_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_ids[k] != k % 2) begin
          errors++;
          $display("FAIL rr_order grant%0d got req%0d required req%0d", k, grant_ids[k], k % 2);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (grant_cycs[k] - rsp_log[k-1] != GAP + 1) begin
          errors++;
          $display("FAIL rr_spacing grant%0d got %0d cycles after rsp required %0d",
                   k, grant_cycs[k] - rsp_log[k-1], GAP + 1);
        end
      end
    end
  endtask

  task automatic test_faults();
    int t;
    miso_zero = 1'b1;
    issue(0, 2'b01, 10'h002, 32'hFFFFFFFF, t);
    wait_drain();
    miso_zero = 1'b0;
    corrupt_addr = 1'b1;
    issue(0, 2'b00, 10'h002, 32'h0, t);
    wait_drain();
    corrupt_addr = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int t;
    int rc0;
    issue(0, 2'b00, 10'h3FF, 32'h0, t);
    void'(sb.pop_back());
    rc0 = rsp_cnt;
    repeat (21) @(negedge sclk);
    checks++;
    if (cs_n !== 1'b0) begin
      errors++;
      $display("FAIL midframe_active got cs_n=%b required 0", cs_n);
    end
    rst = 1'b1;
    @(negedge sclk);
    checks++;
    if (cs_n !== 1'b1 || mosi !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset got cs_n=%b mosi=%b rv=%b required 1 0 0", cs_n, mosi, rsp_valid);
    end
    @(negedge sclk);
    rst = 1'b0;
    repeat (120) @(negedge sclk);
    checks++;
    if (rsp_cnt != rc0) begin
      errors++;
      $display("FAIL abandoned_rsp got %0d responses required 0", rsp_cnt - rc0);
    end
    issue(0, 2'b01, 10'h123, 32'h5A5A5A5A, t);
    wait_drain();
    issue(0, 2'b00, 10'h123, 32'h0, t);
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    miso_zero = 1'b0;
    corrupt_addr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      r_valid[i] = 1'b0;
      r_op[i] = '0;
      r_addr[i] = '0;
      r_wdata[i] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_reserved();
    test_back_to_back();
    test_faults();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
